multicycle_control_unit: RTL and testbench

Multi-cycle RV32I control unit that sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath enables, mux selects and a 4-bit ALU opcode, and performs a ready/request handshake with the data bus. It replaces the single-cycle R-type-only control unit, adds I-type ALU, load, store and branch support, and adds fault reporting. It sits between the instruction register and the datapath/bus interface of the core.

---
 rtl/multicycle_control_unit_if.sv | 34 +++
 rtl/multicycle_control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit port bundle: instruction/bus inputs and datapath controls.
// The slave modport is the control unit; the master modport drives it.
interface multicycle_control_unit_if #(
   parameter int ALU_CTRL_W = 4
);
   logic [31:0]           instrCode;
   logic                  btaken;
   logic                  busReady;
   logic                  irWe;
   logic                  pcEn;
   logic                  pcSrcSel;
   logic                  regFileWe;
   logic                  aluSrcMuxSel;
   logic                  rfWdSrcMuxSel;
   logic [ALU_CTRL_W-1:0] aluControl;
   logic                  busReq;
   logic                  busWe;
   logic                  fault;
   logic                  illegalInstr;

   modport master (
      output instrCode, btaken, busReady,
      input  irWe, pcEn, pcSrcSel, regFileWe, aluSrcMuxSel,
      input  rfWdSrcMuxSel, aluControl, busReq, busWe,
      input  fault, illegalInstr
   );

   modport slave (
      input  instrCode, btaken, busReady,
      output irWe, pcEn, pcSrcSel, regFileWe, aluSrcMuxSel,
      output rfWdSrcMuxSel, aluControl, busReq, busWe,
      output fault, illegalInstr
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (R/I/load/store/branch) with fault reporting.
// Optional bus wait timeout enabled by defining MCU_BUS_TIMEOUT_EN.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input logic clk,
   input logic reset,
   multicycle_control_unit_if.slave bus
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_R_EXE,
      S_I_EXE,
      S_B_EXE,
      S_L_EXE,
      S_L_MEM,
      S_L_WB,
      S_S_EXE,
      S_S_MEM,
      S_FAULT
   } state_e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       r_ok;
   logic       unused_bits;

   assign opcode = bus.instrCode[6:0];
   assign funct3 = bus.instrCode[14:12];
   assign funct7 = bus.instrCode[31:25];
   assign unused_bits = ^{bus.instrCode[24:15],
                          bus.instrCode[11:7]};

   // sub and sra are the only alternate-funct7 R-type ops
   assign r_ok = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) &&
                  ((funct3 == 3'b000) ||
                   (funct3 == 3'b101)));

`ifdef MCU_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
`ifdef MCU_BUS_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               (opcode == OP_R) && r_ok:  state_d = S_R_EXE;
               (opcode == OP_I):          state_d = S_I_EXE;
               (opcode == OP_L):          state_d = S_L_EXE;
               (opcode == OP_S):          state_d = S_S_EXE;
               (opcode == OP_B):          state_d = S_B_EXE;
               default: begin
                  state_d   = S_FAULT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_R_EXE,
         S_I_EXE,
         S_B_EXE: state_d = S_FETCH;
         S_L_EXE: begin
            state_d = S_L_MEM;
`ifdef MCU_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_L_MEM: begin
            if (bus.busReady) begin
               state_d = S_L_WB;
            end
`ifdef MCU_BUS_TIMEOUT_EN
            else if (cnt_q == CNT_MAX) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_L_WB: state_d = S_FETCH;
         S_S_EXE: begin
            state_d = S_S_MEM;
`ifdef MCU_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_S_MEM: begin
            if (bus.busReady) begin
               state_d = S_FETCH;
            end
`ifdef MCU_BUS_TIMEOUT_EN
            else if (cnt_q == CNT_MAX) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
   end

   logic [3:0]            alu4;
   logic [ALU_CTRL_W-1:0] alu_w;

   always_comb begin
      bus.irWe          = 1'b0;
      bus.pcEn          = 1'b0;
      bus.pcSrcSel      = 1'b0;
      bus.regFileWe     = 1'b0;
      bus.aluSrcMuxSel  = 1'b0;
      bus.rfWdSrcMuxSel = 1'b0;
      bus.busReq        = 1'b0;
      bus.busWe         = 1'b0;
      bus.fault         = 1'b0;
      bus.illegalInstr  = 1'b0;
      alu4              = 4'b0000;
      unique case (state_q)
         S_FETCH: bus.irWe = 1'b1;
         S_R_EXE: begin
            bus.regFileWe = 1'b1;
            bus.pcEn      = 1'b1;
            alu4          = {bus.instrCode[30], funct3};
         end
         S_I_EXE: begin
            bus.aluSrcMuxSel = 1'b1;
            bus.regFileWe    = 1'b1;
            bus.pcEn         = 1'b1;
            alu4 = {(funct3 == 3'b101) & bus.instrCode[30],
                    funct3};
         end
         S_B_EXE: begin
            bus.pcEn     = 1'b1;
            bus.pcSrcSel = bus.btaken;
            alu4         = 4'b1000;
         end
         S_L_EXE,
         S_S_EXE: bus.aluSrcMuxSel = 1'b1;
         S_L_MEM: begin
            bus.aluSrcMuxSel = 1'b1;
            bus.busReq       = 1'b1;
         end
         S_L_WB: begin
            bus.rfWdSrcMuxSel = 1'b1;
            bus.regFileWe     = 1'b1;
            bus.pcEn          = 1'b1;
         end
         S_S_MEM: begin
            bus.aluSrcMuxSel = 1'b1;
            bus.busReq       = 1'b1;
            bus.busWe        = 1'b1;
            bus.pcEn         = bus.busReady;
         end
         S_FAULT: begin
            bus.fault        = 1'b1;
            bus.illegalInstr = illegal_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      alu_w      = '0;
      alu_w[3:0] = alu4;
   end

   assign bus.aluControl = alu_w;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected output sequence built
// from the instruction class, compared cycle by cycle.
module tb_multicycle_control_unit;

   localparam int MEM_TIMEOUT = 15;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus ();

   multicycle_control_unit #(
      .ALU_CTRL_W (4),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [13:0] exp_q[$];
   logic        rdy_q[$];

   task automatic chk(input string tag,
                      input logic [13:0] got,
                      input logic [13:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] obs();
      return {bus.irWe, bus.pcEn, bus.pcSrcSel, bus.regFileWe,
              bus.aluSrcMuxSel, bus.rfWdSrcMuxSel, bus.busReq,
              bus.busWe, bus.fault, bus.illegalInstr,
              bus.aluControl[3:0]};
   endfunction

   // fields: irWe pcEn pcSrc rfWe aluSrc wdSrc req we fault ill alu
   function automatic logic [13:0] pk(
      input bit ir, pe, ps, rw, as, rs, br, bw, f, il,
      input logic [3:0] alu);
      return {ir, pe, ps, rw, as, rs, br, bw, f, il, alu};
   endfunction

   function automatic void push(input logic [13:0] e,
                                input logic r);
      exp_q.push_back(e);
      rdy_q.push_back(r);
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   // Memory phase: waits low cycles then one ready cycle.
   // Returns 1 when the bus times out into FAULT.
   function automatic bit mem_phase(input int waits, input bit st);
`ifdef MCU_BUS_TIMEOUT_EN
      if (waits > MEM_TIMEOUT) begin
         for (int w = 0; w <= MEM_TIMEOUT; w++)
            push(pk(0,0,0,0,1,0,1,st,0,0,4'h0), 1'b0);
         for (int k = 0; k < 3; k++)
            push(pk(0,0,0,0,0,0,0,0,1,0,4'h0), rnd1());
         return 1'b1;
      end
`endif
      for (int w = 0; w < waits; w++)
         push(pk(0,0,0,0,1,0,1,st,0,0,4'h0), 1'b0);
      push(pk(0,st,0,0,1,0,1,st,0,0,4'h0), 1'b1);
      return 1'b0;
   endfunction

   function automatic bit build(input logic [31:0] ins,
                                input int waits,
                                input logic bt);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      bit ill;
      op  = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      ill = 1'b0;
      push(pk(1,0,0,0,0,0,0,0,0,0,4'h0), rnd1());
      push(pk(0,0,0,0,0,0,0,0,0,0,4'h0), rnd1());
      case (op)
         7'h33: begin
            if (f7 == 7'h00 ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
               push(pk(0,1,0,1,0,0,0,0,0,0,{ins[30], f3}), rnd1());
            else
               ill = 1'b1;
         end
         7'h13: push(pk(0,1,0,1,1,0,0,0,0,0,
                        {f3 == 3'd5 ? ins[30] : 1'b0, f3}), rnd1());
         7'h63: push(pk(0,1,bt,0,0,0,0,0,0,0,4'h8), rnd1());
         7'h03: begin
            push(pk(0,0,0,0,1,0,0,0,0,0,4'h0), rnd1());
            if (mem_phase(waits, 1'b0))
               return 1'b1;
            push(pk(0,1,0,1,0,1,0,0,0,0,4'h0), rnd1());
         end
         7'h23: begin
            push(pk(0,0,0,0,1,0,0,0,0,0,4'h0), rnd1());
            if (mem_phase(waits, 1'b1))
               return 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (ill)
         for (int k = 0; k < 3; k++)
            push(pk(0,0,0,0,0,0,0,0,1,1,4'h0), rnd1());
      return ill;
   endfunction

   task automatic do_reset(input string tag);
      #3;
      reset = 1'b0;
      #1;
      chk({tag, "_rst"}, obs(), pk(1,0,0,0,0,0,0,0,0,0,4'h0));
      @(posedge clk);
      #1;
      chk({tag, "_rst_hold"}, obs(),
          pk(1,0,0,0,0,0,0,0,0,0,4'h0));
      reset = 1'b1;
   endtask

   // maxcyc < 0 runs the whole instruction; otherwise reset mid-flight
   task automatic run(input string tag, input logic [31:0] ins,
                      input int waits, input logic bt,
                      input int maxcyc);
      bit need_rst;
      int c;
      exp_q.delete();
      rdy_q.delete();
      need_rst = build(ins, waits, bt);
      bus.instrCode = ins;
      bus.btaken    = bt;
      c = 0;
      while (exp_q.size() > 0 && (maxcyc < 0 || c < maxcyc)) begin
         bus.busReady = rdy_q.pop_front();
         #2;
         chk($sformatf("%s_c%0d", tag, c), obs(), exp_q.pop_front());
         @(posedge clk);
         #1;
         c++;
      end
      bus.busReady = 1'b0;
      if (need_rst || maxcyc >= 0)
         do_reset(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  f7;
      int k;
      ins = $urandom;
      k   = $urandom_range(0, 9);
      case (k)
         0, 1: begin
            ins[6:0] = 7'h33;
            case ($urandom_range(0, 3))
               0, 1: f7 = 7'h00;
               2:    f7 = 7'h20;
               default: f7 = 7'($urandom);
            endcase
            ins[31:25] = f7;
         end
         2, 3: ins[6:0] = 7'h13;
         4:    ins[6:0] = 7'h03;
         5:    ins[6:0] = 7'h23;
         6, 7: ins[6:0] = 7'h63;
         8:    ins[6:0] = 7'($urandom);
         default: ;
      endcase
      return ins;
   endfunction

   initial begin
      reset         = 1'b0;
      bus.instrCode = 32'h0;
      bus.btaken    = 1'b0;
      bus.busReady  = 1'b0;
      #1;
      chk("por", obs(), pk(1,0,0,0,0,0,0,0,0,0,4'h0));
      @(posedge clk);
      #1;
      reset = 1'b1;

      run("add",  32'h002081B3, 0, 1'b0, -1);
      run("sub",  32'h40208133, 0, 1'b0, -1);
      run("srai", 32'h4030D093, 0, 1'b0, -1);
      run("andi", 32'h0FF0F093, 0, 1'b0, -1);
      run("lw",   32'h0000A183, 3, 1'b0, -1);
      run("sw0",  32'h0030A023, 0, 1'b0, -1);
      run("beq1", 32'h00208463, 0, 1'b1, -1);
      run("beq0", 32'h00208463, 0, 1'b0, -1);
      run("badop", 32'h0000007F, 0, 1'b0, -1);
      run("badf7", 32'h402091B3, 0, 1'b0, -1);
      run("lwrst", 32'h0000A183, 10, 1'b0, 5);
      run("after", 32'h002081B3, 0, 1'b0, -1);
`ifdef MCU_BUS_TIMEOUT_EN
      run("swto", 32'h0030A023, MEM_TIMEOUT + 5, 1'b0, -1);
`endif

      for (int i = 0; i < 300; i++)
         run($sformatf("rnd%0d", i), rand_instr(),
             $urandom_range(0, 4), rnd1(), -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
